asrv32_writeback: RTL and testbench
===================================

Name: asrv32_writeback

Overview:
Final pipeline stage, directly downstream of the memory-access stage. It consumes the MEM/WB pipeline registers and commits results to the base register file. Loaded data is selected for load instructions and the ALU/rd value for everything else. It also detects misaligned accesses, ECALL, EBREAK and MRET. For these it records trap state, redirects the PC and flushes all earlier stages through a small trap/redirect FSM.

Parameters:
TRAP_VECTOR, 32'h0000_0004, PC loaded on any trap entry
FLUSH_CYCLES, 2, cycles o_flush stays asserted after the detect cycle (range 1..7)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_ce  in  1  stage valid/clock-enable from memory-access stage
i_opcode_memwb  in  `OPCODE_WIDTH  one-hot opcode (`LOAD, `STORE, `SYSTEM bits used)
i_funct3_memwb  in  3  access width: 00 byte, 01 half, 10 word
i_result_from_alu_memwb  in  32  data memory address
i_pc_memwb  in  32  PC of the instruction
i_load_data  in  32  extended load data from memory-access stage
i_wr_rd  in  1  rd write request
i_rd_addr  in  5  rd index
i_rd  in  32  non-load rd value
i_is_ecall / i_is_ebreak / i_is_mret  in  1 each  decoded SYSTEM flags
o_wr_rd  out  1  base-register write enable (combinational)
o_rd_addr  out  5  base-register write index (combinational)
o_rd_data  out  32  base-register write data (combinational)
o_change_pc  out  1  PC redirect request to fetch
o_next_pc  out  32  redirect target
o_flush  out  1  flush all earlier stages
o_mepc / o_mtval  out  32 each  trap PC and trap value
o_mcause  out  4  trap cause code
o_trap_active  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; flush counter 0; o_mepc/o_mtval/o_mcause 0. All outputs are 0 while reset is asserted, including mid-trap.
- Valid instruction: v = i_ce && state==IDLE.
- Misalignment, computed on i_result_from_alu_memwb[1:0]:
  - half-word: addr[0]=1 is misaligned.
  - word: addr[1:0]!=0 is misaligned.
  - byte: never misaligned.
  - Applies to LOAD (cause 4) and STORE (cause 6).
- Trap priority: misaligned LOAD/STORE > EBREAK (cause 3, mtval=pc) > ECALL (cause 11, mtval=0). Misaligned mtval = address.
- Writeback is combinational, zero latency:
  - o_wr_rd = v && i_wr_rd && i_rd_addr!=0 && !trap.
  - o_rd_data = i_opcode_memwb[`LOAD] ? i_load_data : i_rd.
  - A trapping instruction never writes rd.
- Detect cycle: v && (trap || i_is_mret).
  - o_change_pc=1 and o_flush=1 combinationally in the same cycle.
  - o_next_pc = TRAP_VECTOR for a trap, o_mepc for MRET.
  - Trap: on the clock edge, mepc<=pc, mcause, mtval are latched. MRET leaves them unchanged.
  - Counter loads FLUSH_CYCLES; state goes to REDIRECT.
- REDIRECT:
  - o_flush=1, o_change_pc=0, o_trap_active=1.
  - Counter decrements each cycle; at count 1 → IDLE.
  - Any i_ce during REDIRECT is discarded: no rd write, no new trap.
- Idle with no event: o_flush=0, o_change_pc=0, o_next_pc=0.
- Store instructions write memory upstream. A misaligned store still traps here, but its memory side effect is not cancelled.
- MRET while trap registers are still 0 returns to PC 0. This is legal behaviour.

Decomposition:
- Shared package/header (asrv32_header.vh):
  - opcode bit indices (`LOAD, `STORE, `SYSTEM);
  - mcause constants: MISALIGNED_LOAD=4, MISALIGNED_STORE=6, EBREAK=3, ECALL_M=11;
  - FSM state encoding IDLE/REDIRECT.
- One natural sub-module, asrv32_trap_detect: combinational misalignment check plus priority encoding to {trap, cause, tval}.

Test Plan:
1. LW, addr 0x100, i_load_data 0xDEADBEEF, rd=5, i_ce=1 → same cycle: o_wr_rd=1, o_rd_addr=5, o_rd_data=0xDEADBEEF; o_flush=0.
2. ADD with i_rd=0x1234, rd=0 → o_wr_rd=0. With rd=3 → o_rd_data=0x1234, not i_load_data.
3. LH, addr 0x203, pc 0x40 →
   - detect cycle: o_wr_rd=0, o_change_pc=1, o_next_pc=TRAP_VECTOR, o_flush=1;
   - next edge: o_mepc=0x40, o_mcause=4, o_mtval=0x203;
   - o_flush stays high FLUSH_CYCLES more cycles; i_ce pulses during that window produce no writes.
4. ECALL at pc 0x80, then MRET → ECALL gives o_mcause=11, o_mtval=0. MRET detect gives o_next_pc=0x80, with mepc unchanged.
5. SW to 0x102 arriving together with an EBREAK flag → cause 6 wins (misaligned has priority); o_mtval=0x102.
6. i_rst_n pulsed low mid-REDIRECT → o_flush, o_trap_active and trap registers drop to 0 immediately. The first valid instruction after release writes back normally.

Source files
------------

// File: rtl/asrv32_writeback_pkg.sv
// asrv32_writeback_pkg: shared opcode indices, trap causes, access widths and FSM states
package asrv32_writeback_pkg;
    localparam int OPCODE_WIDTH = 11;
    localparam int OP_LOAD = 2;
    localparam int OP_STORE = 3;
    localparam int OP_SYSTEM = 9;
    localparam logic [1:0] F3_HALF = 2'b01;
    localparam logic [1:0] F3_WORD = 2'b10;
    localparam logic [3:0] MISALIGNED_LOAD = 4'd4;
    localparam logic [3:0] MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] EBREAK = 4'd3;
    localparam logic [3:0] ECALL_M = 4'd11;
    typedef enum logic {IDLE, REDIRECT} state_t;
endpackage

// File: rtl/asrv32_writeback_trap_detect.sv
// asrv32_writeback_trap_detect: misalignment check and trap priority encoder
// Inputs:  is_load/is_store, width (funct3[1:0]), addr, pc, is_ecall, is_ebreak
// Outputs: trap, cause (mcause code), tval (mtval value)
module asrv32_writeback_trap_detect
    import asrv32_writeback_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  width,
    input  logic [31:0] addr,
    input  logic [31:0] pc,
    input  logic        is_ecall,
    input  logic        is_ebreak,
    output logic        trap,
    output logic [3:0]  cause,
    output logic [31:0] tval
);
    logic mis;
    always_comb begin
        mis = (is_load || is_store) &&
              ((width == F3_HALF && addr[0]) || (width == F3_WORD && addr[1:0] != 2'b00));
        trap = mis || is_ebreak || is_ecall;
        cause = mis ? (is_load ? MISALIGNED_LOAD : MISALIGNED_STORE) :
                is_ebreak ? EBREAK : is_ecall ? ECALL_M : 4'd0;
        tval = mis ? addr : is_ebreak ? pc : 32'd0;
    end
endmodule

// File: rtl/asrv32_writeback.sv
// asrv32_writeback: register-file commit plus trap/MRET redirect and flush FSM
// Inputs:  i_clk, i_rst_n, i_ce, MEM/WB opcode/funct3/address/pc, i_load_data,
//          i_wr_rd/i_rd_addr/i_rd, decoded i_is_ecall/i_is_ebreak/i_is_mret
// Outputs: o_wr_rd/o_rd_addr/o_rd_data (combinational commit), o_change_pc/o_next_pc,
//          o_flush, o_mepc/o_mtval/o_mcause trap state, o_trap_active
module asrv32_writeback
    import asrv32_writeback_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ce,
    input  logic [OPCODE_WIDTH-1:0] i_opcode_memwb,
    input  logic [2:0]              i_funct3_memwb,
    input  logic [31:0]             i_result_from_alu_memwb,
    input  logic [31:0]             i_pc_memwb,
    input  logic [31:0]             i_load_data,
    input  logic                    i_wr_rd,
    input  logic [4:0]              i_rd_addr,
    input  logic [31:0]             i_rd,
    input  logic                    i_is_ecall,
    input  logic                    i_is_ebreak,
    input  logic                    i_is_mret,
    output logic                    o_wr_rd,
    output logic [4:0]              o_rd_addr,
    output logic [31:0]             o_rd_data,
    output logic                    o_change_pc,
    output logic [31:0]             o_next_pc,
    output logic                    o_flush,
    output logic [31:0]             o_mepc,
    output logic [31:0]             o_mtval,
    output logic [3:0]              o_mcause,
    output logic                    o_trap_active
);
    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic v, trap, detect;
    logic [3:0] cause;
    logic [31:0] tval;
    logic unused_bits;
    assign unused_bits = ^{i_opcode_memwb, i_funct3_memwb[2]};
    asrv32_writeback_trap_detect u_detect (
        .is_load(i_opcode_memwb[OP_LOAD]),
        .is_store(i_opcode_memwb[OP_STORE]),
        .width(i_funct3_memwb[1:0]),
        .addr(i_result_from_alu_memwb),
        .pc(i_pc_memwb),
        .is_ecall(i_is_ecall),
        .is_ebreak(i_is_ebreak),
        .trap(trap),
        .cause(cause),
        .tval(tval)
    );
    // i_rst_n gates the combinational outputs so everything reads 0 while reset is held
    always_comb begin
        v = i_rst_n && i_ce && state == IDLE;
        detect = v && (trap || i_is_mret);
        o_wr_rd = v && i_wr_rd && i_rd_addr != 5'd0 && !trap;
        o_rd_addr = i_rst_n ? i_rd_addr : 5'd0;
        o_rd_data = !i_rst_n ? 32'd0 : i_opcode_memwb[OP_LOAD] ? i_load_data : i_rd;
        o_change_pc = detect;
        o_next_pc = !detect ? 32'd0 : trap ? TRAP_VECTOR : o_mepc;
        o_flush = detect || state == REDIRECT;
        o_trap_active = state == REDIRECT;
        state_nx = detect ? REDIRECT : (state == REDIRECT && cnt == 3'd1) ? IDLE : state;
        cnt_nx = detect ? 3'(FLUSH_CYCLES) : state == REDIRECT ? cnt - 3'd1 : cnt;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt <= 3'd0;
            o_mepc <= 32'd0;
            o_mtval <= 32'd0;
            o_mcause <= 4'd0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (detect && trap) begin
                o_mepc <= i_pc_memwb;
                o_mtval <= tval;
                o_mcause <= cause;
            end
        end
    end
endmodule

// File: tb/tb_asrv32_writeback.sv
// tb_asrv32_writeback: vector table with expected-result queue plus trap/MRET/reset sequences
module tb_asrv32_writeback;
    import asrv32_writeback_pkg::*;
    localparam logic [31:0] TV = 32'h0000_0004;
    localparam int FC = 2;
    localparam logic [OPCODE_WIDTH-1:0] OPL = 11'b1 << OP_LOAD;
    localparam logic [OPCODE_WIDTH-1:0] OPS = 11'b1 << OP_STORE;
    localparam logic [OPCODE_WIDTH-1:0] OPY = 11'b1 << OP_SYSTEM;
    localparam logic [OPCODE_WIDTH-1:0] OPR = 11'b1;
    logic i_clk = 0, i_rst_n = 0, i_ce = 0;
    logic [OPCODE_WIDTH-1:0] i_opcode_memwb = '0;
    logic [2:0] i_funct3_memwb = 0;
    logic [31:0] i_result_from_alu_memwb = 0, i_pc_memwb = 0, i_load_data = 0, i_rd = 0;
    logic i_wr_rd = 0, i_is_ecall = 0, i_is_ebreak = 0, i_is_mret = 0;
    logic [4:0] i_rd_addr = 0;
    logic o_wr_rd, o_change_pc, o_flush, o_trap_active;
    logic [4:0] o_rd_addr;
    logic [31:0] o_rd_data, o_next_pc, o_mepc, o_mtval;
    logic [3:0] o_mcause;
    int n_tests = 0, n_fail = 0;
    asrv32_writeback #(.TRAP_VECTOR(TV), .FLUSH_CYCLES(FC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_opcode_memwb(i_opcode_memwb),
        .i_funct3_memwb(i_funct3_memwb), .i_result_from_alu_memwb(i_result_from_alu_memwb),
        .i_pc_memwb(i_pc_memwb), .i_load_data(i_load_data), .i_wr_rd(i_wr_rd),
        .i_rd_addr(i_rd_addr), .i_rd(i_rd), .i_is_ecall(i_is_ecall), .i_is_ebreak(i_is_ebreak),
        .i_is_mret(i_is_mret), .o_wr_rd(o_wr_rd), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
        .o_change_pc(o_change_pc), .o_next_pc(o_next_pc), .o_flush(o_flush), .o_mepc(o_mepc),
        .o_mtval(o_mtval), .o_mcause(o_mcause), .o_trap_active(o_trap_active)
    );
    always #5 i_clk = ~i_clk;
    typedef struct {
        logic ce; logic [OPCODE_WIDTH-1:0] op; logic [2:0] f3; logic [31:0] addr, ld, rd;
        logic wr; logic [4:0] ra;
        logic e_wr; logic [4:0] e_ra; logic [31:0] e_data; logic e_chg, e_flush;
    } vec_t;
    typedef struct {logic wr; logic [4:0] ra; logic [31:0] data; logic chg, flush;} exp_t;
    vec_t vecs[8];
    exp_t sb[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic drive(input logic ce, input logic [OPCODE_WIDTH-1:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] ld,
                         input logic wr, input logic [4:0] ra, input logic [31:0] rd,
                         input logic ec, input logic eb, input logic mr);
        @(negedge i_clk);
        i_ce = ce; i_opcode_memwb = op; i_funct3_memwb = f3; i_result_from_alu_memwb = addr;
        i_pc_memwb = pc; i_load_data = ld; i_wr_rd = wr; i_rd_addr = ra; i_rd = rd;
        i_is_ecall = ec; i_is_ebreak = eb; i_is_mret = mr;
        #1;
    endtask
    task automatic idle_cycle();
        drive(0, OPR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    // Walks the flush window after a detect cycle, offering a writing instruction each cycle
    task automatic redirect_window(input string tag);
        for (int i = 0; i < FC; i++) begin
            drive(1, OPR, 0, 0, 32'h900, 0, 1, 5'd9, 32'h5555, 0, 0, 0);
            chk({tag, " flush"}, 32'(o_flush), 1);
            chk({tag, " active"}, 32'(o_trap_active), 1);
            chk({tag, " no_wr"}, 32'(o_wr_rd), 0);
            chk({tag, " no_chg"}, 32'(o_change_pc), 0);
        end
        drive(1, OPR, 0, 0, 32'h904, 0, 1, 5'd9, 32'h5555, 0, 0, 0);
        chk({tag, " flush_end"}, 32'(o_flush), 0);
        chk({tag, " active_end"}, 32'(o_trap_active), 0);
        chk({tag, " wr_after"}, 32'(o_wr_rd), 1);
    endtask
    initial begin
        vecs[0] = '{1, OPL, 3'b010, 32'h100, 32'hDEADBEEF, 32'h1, 1, 5'd5, 1, 5'd5, 32'hDEADBEEF, 0, 0};
        vecs[1] = '{1, OPR, 3'b000, 32'h0, 32'hAAAA, 32'h1234, 1, 5'd0, 0, 5'd0, 32'h1234, 0, 0};
        vecs[2] = '{1, OPR, 3'b000, 32'h0, 32'hAAAA, 32'h1234, 1, 5'd3, 1, 5'd3, 32'h1234, 0, 0};
        vecs[3] = '{1, OPL, 3'b000, 32'h103, 32'h7F, 32'h2, 1, 5'd4, 1, 5'd4, 32'h7F, 0, 0};
        vecs[4] = '{1, OPL, 3'b001, 32'h102, 32'hFFFF8000, 32'h2, 1, 5'd6, 1, 5'd6, 32'hFFFF8000, 0, 0};
        vecs[5] = '{1, OPS, 3'b010, 32'h104, 32'h0, 32'h3, 0, 5'd0, 0, 5'd0, 32'h3, 0, 0};
        vecs[6] = '{0, OPR, 3'b000, 32'h0, 32'h0, 32'h77, 1, 5'd8, 0, 5'd8, 32'h77, 0, 0};
        vecs[7] = '{1, OPL, 3'b101, 32'h106, 32'hBEEF, 32'h4, 1, 5'd31, 1, 5'd31, 32'hBEEF, 0, 0};
        // reset held with a writing instruction present: everything reads 0
        i_ce = 1; i_opcode_memwb = OPL; i_funct3_memwb = 3'b010; i_wr_rd = 1; i_rd_addr = 5;
        i_load_data = 32'h1111;
        #12;
        chk("rst wr_rd", 32'(o_wr_rd), 0);
        chk("rst rd_data", o_rd_data, 0);
        chk("rst flush", 32'(o_flush), 0);
        chk("rst mepc", o_mepc, 0);
        chk("rst mcause", 32'(o_mcause), 0);
        @(negedge i_clk);
        i_rst_n = 1;
        foreach (vecs[k]) begin
            drive(vecs[k].ce, vecs[k].op, vecs[k].f3, vecs[k].addr, 32'h10, vecs[k].ld,
                  vecs[k].wr, vecs[k].ra, vecs[k].rd, 0, 0, 0);
            sb.push_back('{vecs[k].e_wr, vecs[k].e_ra, vecs[k].e_data, vecs[k].e_chg, vecs[k].e_flush});
            begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("vec%0d wr_rd", k), 32'(o_wr_rd), 32'(e.wr));
                chk($sformatf("vec%0d rd_addr", k), 32'(o_rd_addr), 32'(e.ra));
                chk($sformatf("vec%0d rd_data", k), o_rd_data, e.data);
                chk($sformatf("vec%0d change_pc", k), 32'(o_change_pc), 32'(e.chg));
                chk($sformatf("vec%0d flush", k), 32'(o_flush), 32'(e.flush));
            end
        end
        // misaligned LH
        drive(1, OPL, 3'b001, 32'h203, 32'h40, 32'h1, 1, 5'd7, 0, 0, 0, 0);
        chk("lh wr_rd", 32'(o_wr_rd), 0);
        chk("lh change_pc", 32'(o_change_pc), 1);
        chk("lh next_pc", o_next_pc, TV);
        chk("lh flush", 32'(o_flush), 1);
        chk("lh active_detect", 32'(o_trap_active), 0);
        @(posedge i_clk); #1;
        chk("lh mepc", o_mepc, 32'h40);
        chk("lh mcause", 32'(o_mcause), 4);
        chk("lh mtval", o_mtval, 32'h203);
        redirect_window("lh");
        // ECALL then MRET
        drive(1, OPY, 0, 0, 32'h80, 0, 0, 0, 0, 1, 0, 0);
        chk("ecall next_pc", o_next_pc, TV);
        chk("ecall change_pc", 32'(o_change_pc), 1);
        @(posedge i_clk); #1;
        chk("ecall mcause", 32'(o_mcause), 11);
        chk("ecall mtval", o_mtval, 0);
        chk("ecall mepc", o_mepc, 32'h80);
        redirect_window("ecall");
        drive(1, OPY, 0, 0, 32'h200, 0, 0, 0, 0, 0, 0, 1);
        chk("mret change_pc", 32'(o_change_pc), 1);
        chk("mret next_pc", o_next_pc, 32'h80);
        chk("mret flush", 32'(o_flush), 1);
        @(posedge i_clk); #1;
        chk("mret mepc", o_mepc, 32'h80);
        chk("mret mcause", 32'(o_mcause), 11);
        redirect_window("mret");
        // misaligned SW together with EBREAK
        drive(1, OPS, 3'b010, 32'h102, 32'h300, 0, 0, 0, 0, 0, 1, 0);
        chk("sw next_pc", o_next_pc, TV);
        @(posedge i_clk); #1;
        chk("sw mcause", 32'(o_mcause), 6);
        chk("sw mtval", o_mtval, 32'h102);
        chk("sw mepc", o_mepc, 32'h300);
        redirect_window("sw");
        // plain EBREAK
        drive(1, OPY, 0, 0, 32'h400, 0, 0, 0, 0, 0, 1, 0);
        @(posedge i_clk); #1;
        chk("ebreak mcause", 32'(o_mcause), 3);
        chk("ebreak mtval", o_mtval, 32'h400);
        redirect_window("ebreak");
        // reset pulse in the middle of a flush window
        drive(1, OPL, 3'b010, 32'h201, 32'h500, 0, 1, 5'd2, 0, 0, 0, 0);
        chk("rw change_pc", 32'(o_change_pc), 1);
        idle_cycle();
        chk("rw active", 32'(o_trap_active), 1);
        i_rst_n = 0;
        #1;
        chk("rw rst flush", 32'(o_flush), 0);
        chk("rw rst active", 32'(o_trap_active), 0);
        chk("rw rst mepc", o_mepc, 0);
        chk("rw rst mtval", o_mtval, 0);
        chk("rw rst mcause", 32'(o_mcause), 0);
        @(negedge i_clk);
        i_rst_n = 1;
        drive(1, OPL, 3'b010, 32'h300, 32'h504, 32'hCAFEF00D, 1, 5'd6, 32'h1, 0, 0, 0);
        chk("post_rst wr_rd", 32'(o_wr_rd), 1);
        chk("post_rst rd_data", o_rd_data, 32'hCAFEF00D);
        chk("post_rst flush", 32'(o_flush), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
